// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   RegBus      : width of the address/data bus
//   ByteEnAll   : byte enables used for instruction fetches
//   Enable/Disable : single-bit control constants
//   arb_state_e : arbiter FSM states (IDLE, DATA, INST)
//   timeout_last(): terminal value of the wait counter for a given timeout
package mem_bus_arbiter_pkg;

    localparam int         RegBus    = 32;
    localparam int         CntW      = 8;
    localparam logic [3:0] ByteEnAll = 4'b1111;
    localparam logic       Enable    = 1'b1;
    localparam logic       Disable   = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } arb_state_e;

    // The counter starts at 0 in the first bus_ce cycle, so the abort
    // decision is taken when it holds TIMEOUT-1.
    function automatic logic [CntW-1:0] timeout_last(input int unsigned to);
        return CntW'(to - 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit external memory bus between the
// instruction-fetch port and the load/store port.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_done) and PC
//   if_flush            discard the fetch currently on the bus
//   if_rdata/if_done    fetched word and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_sel
//                       load/store request (held until mem_done)
//   mem_rdata/mem_done  load data and its one-cycle completion pulse
//   stallreq_if/_mem    pipeline stall requests
//   bus_ce/we/addr/wdata/be  registered bus master outputs
//   bus_rdata/bus_ack   slave read data and completion
//   bus_err             one-cycle pulse when a bus cycle times out
//   dbg_state_o         current FSM state, for observation only
//
// Handshake: a port raises its req and holds it, with stable attributes,
// until the cycle in which its done pulses; a cycle with done high never
// starts a new grant for that same port. On the bus, bus_ce stays high from
// the cycle after the grant until bus_ack is sampled high on a rising edge
// or the wait counter expires; there is no preemption.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [RegBus-1:0] if_addr,
    input  logic              if_flush,
    output logic [RegBus-1:0] if_rdata,
    output logic              if_done,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [RegBus-1:0] mem_addr,
    input  logic [RegBus-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [RegBus-1:0] mem_rdata,
    output logic              mem_done,

    output logic              stallreq_if,
    output logic              stallreq_mem,

    output logic              bus_ce,
    output logic              bus_we,
    output logic [RegBus-1:0] bus_addr,
    output logic [RegBus-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic [RegBus-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,

    output logic [1:0]        dbg_state_o
);

    localparam logic [CntW-1:0] TO_LAST = timeout_last(TIMEOUT);

    arb_state_e        state_q,     state_d;
    logic [CntW-1:0]   cnt_q,       cnt_d;
    logic              discard_q,   discard_d;
    logic              bus_ce_q,    bus_ce_d;
    logic              bus_we_q,    bus_we_d;
    logic [RegBus-1:0] bus_addr_q,  bus_addr_d;
    logic [RegBus-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q,    bus_be_d;
    logic              bus_err_q,   bus_err_d;
    logic              if_done_q,   if_done_d;
    logic [RegBus-1:0] if_rdata_q,  if_rdata_d;
    logic              mem_done_q,  mem_done_d;
    logic [RegBus-1:0] mem_rdata_q, mem_rdata_d;

    logic              discard_now;
    logic              cnt_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            discard_q   <= Disable;
            bus_ce_q    <= Disable;
            bus_we_q    <= Disable;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_err_q   <= Disable;
            if_done_q   <= Disable;
            if_rdata_q  <= '0;
            mem_done_q  <= Disable;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = Disable;
        if_done_d   = Disable;
        if_rdata_d  = if_rdata_q;
        mem_done_d  = Disable;
        mem_rdata_d = mem_rdata_q;

        // A flush seen in the completing cycle still cancels the fetch.
        discard_now = discard_q | if_flush;
        cnt_expired = (cnt_q == TO_LAST);

        unique case (state_q)
            ST_IDLE: begin
                discard_d = Disable;
                // The done checks stop a still-held request from being
                // re-issued in the very cycle its access retires.
                if (mem_req && !mem_done_q) begin
                    state_d     = ST_DATA;
                    cnt_d       = '0;
                    bus_ce_d    = Enable;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_be_d    = mem_sel;
                end else if (if_req && !if_done_q) begin
                    state_d     = ST_INST;
                    cnt_d       = '0;
                    bus_ce_d    = Enable;
                    bus_we_d    = Disable;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_be_d    = ByteEnAll;
                end
            end

            ST_DATA: begin
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_ce_d    = Disable;
                    bus_we_d    = Disable;
                    mem_done_d  = Enable;
                    mem_rdata_d = bus_rdata;
                end else if (cnt_expired) begin
                    state_d     = ST_IDLE;
                    bus_ce_d    = Disable;
                    bus_we_d    = Disable;
                    bus_err_d   = Enable;
                    mem_done_d  = Enable;
                    mem_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_INST: begin
                if (bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_ce_d  = Disable;
                    bus_we_d  = Disable;
                    discard_d = Disable;
                    if (!discard_now) begin
                        if_done_d  = Enable;
                        if_rdata_d = bus_rdata;
                    end
                end else if (cnt_expired) begin
                    state_d   = ST_IDLE;
                    bus_ce_d  = Disable;
                    bus_we_d  = Disable;
                    bus_err_d = Enable;
                    discard_d = Disable;
                    if (!discard_now) begin
                        if_done_d  = Enable;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    discard_d = discard_now;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stallreq_if  = if_req  & ~if_done_q;
    assign stallreq_mem = mem_req & ~mem_done_q;

    assign if_rdata    = if_rdata_q;
    assign if_done     = if_done_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_done    = mem_done_q;
    assign bus_ce      = bus_ce_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign bus_err     = bus_err_q;
    assign dbg_state_o = state_q;

endmodule
